// File: rtl/lsu_wb_queue.sv
// In-order writeback queue: buffers ALU results and outstanding loads, masks load data,
// and retires entries to the register file; responses for cancelled loads are absorbed by a drop counter.
module lsu_wb_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_WIDTH   = 5,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cancel_i,
    input  logic                  hold_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_result_i,
    input  logic                  in_is_load_i,
    input  logic                  in_wen_i,
    input  logic [RD_WIDTH-1:0]   in_rd_i,
    input  logic [2:0]            in_func3_i,
    input  logic                  in_fence_i,
    input  logic                  mem_data_ok_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  wb_valid_o,
    input  logic                  wb_ready_i,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    output logic [RD_WIDTH-1:0]   wb_rd_o,
    output logic                  wb_wen_o,
    output logic                  wb_fence_o,
    output logic                  load_pending_o,
    output logic                  empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int LW = $clog2(DATA_WIDTH / 8);

    logic [DATA_WIDTH-1:0] result_q [DEPTH];
    logic [DATA_WIDTH-1:0] raw_q    [DEPTH];
    logic [RD_WIDTH-1:0]   rd_q     [DEPTH];
    logic [2:0]            func3_q  [DEPTH];
    logic [DEPTH-1:0]      is_load_q;
    logic [DEPTH-1:0]      wen_q;
    logic [DEPTH-1:0]      fence_q;
    logic [DEPTH-1:0]      dv_q;

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d, drop_q, drop_d;

    logic [PW-1:0] idx, resp_ptr;
    logic [CW-1:0] pend_cnt;
    logic          resp_found, resp_take, head_byp, enq, commit, is_empty;
    logic [DATA_WIDTH-1:0] head_raw;

    function automatic logic [DATA_WIDTH-1:0] load_mask(
        input logic [DATA_WIDTH-1:0] raw,
        input logic [LW-1:0]         lane,
        input logic [2:0]            f3
    );
        logic [DATA_WIDTH-1:0] b, h, w, r;
        logic [LW-1:0]         lane_h, lane_w;
        lane_h = lane & ~LW'(1);
        lane_w = lane & ~LW'(3);
        b = raw >> {lane, 3'b000};
        h = raw >> {lane_h, 3'b000};
        w = raw >> {lane_w, 3'b000};
        case (f3)
            3'b000:  begin r = {DATA_WIDTH{b[7]}};  r[7:0]  = b[7:0];  end
            3'b001:  begin r = {DATA_WIDTH{h[15]}}; r[15:0] = h[15:0]; end
            3'b010:  begin r = {DATA_WIDTH{w[31]}}; r[31:0] = w[31:0]; end
            3'b100:  begin r = '0; r[7:0]  = b[7:0];  end
            3'b101:  begin r = '0; r[15:0] = h[15:0]; end
            3'b110:  begin r = '0; r[31:0] = w[31:0]; end
            default: r = raw;
        endcase
        return r;
    endfunction

    // Oldest load still waiting for data, scanned in program order from the head.
    always_comb begin
        idx        = head_q;
        resp_ptr   = head_q;
        resp_found = 1'b0;
        pend_cnt   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (CW'(i) < count_q && is_load_q[idx] && !dv_q[idx]) begin
                pend_cnt = pend_cnt + 1'b1;
                if (!resp_found) begin
                    resp_found = 1'b1;
                    resp_ptr   = idx;
                end
            end
        end
    end

    always_comb begin
        is_empty   = (count_q == '0);
        resp_take  = mem_data_ok_i && (drop_q == '0) && resp_found;
        head_byp   = resp_take && (resp_ptr == head_q);
        wb_valid_o = !is_empty && (dv_q[head_q] || head_byp);
        commit     = wb_valid_o && wb_ready_i && !hold_i;
        in_ready_o = (count_q < CW'(DEPTH)) && (drop_q == '0) && !cancel_i;
        enq        = in_valid_i && in_ready_o;
        head_raw   = head_byp ? mem_rdata_i : raw_q[head_q];

        empty_o        = is_empty;
        load_pending_o = resp_found;
        wb_wen_o       = wb_valid_o && wen_q[head_q];
        wb_fence_o     = wb_valid_o && fence_q[head_q];
        wb_rd_o        = is_empty ? '0 : rd_q[head_q];
        if (is_empty)
            wb_data_o = '0;
        else if (is_load_q[head_q])
            wb_data_o = load_mask(head_raw, result_q[head_q][LW-1:0], func3_q[head_q]);
        else
            wb_data_o = result_q[head_q];
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        drop_d  = drop_q;
        count_d = count_q + CW'(enq) - CW'(commit);
        if (enq)    tail_d = tail_q + 1'b1;
        if (commit) head_d = head_q + 1'b1;
        if (drop_q != '0 && mem_data_ok_i) drop_d = drop_q - 1'b1;
        // A response consumed this cycle is never owed again, whether its entry retires or is flushed.
        if (cancel_i) begin
            head_d  = tail_q;
            count_d = '0;
            drop_d  = drop_d + pend_cnt - CW'(resp_take);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            drop_q  <= '0;
            dv_q    <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            drop_q  <= drop_d;
            if (resp_take) dv_q[resp_ptr] <= 1'b1;
            if (enq)       dv_q[tail_q]   <= !in_is_load_i;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            result_q[tail_q]  <= in_result_i;
            is_load_q[tail_q] <= in_is_load_i;
            wen_q[tail_q]     <= in_wen_i;
            rd_q[tail_q]      <= in_rd_i;
            func3_q[tail_q]   <= in_func3_i;
            fence_q[tail_q]   <= in_fence_i;
        end
        if (resp_take) raw_q[resp_ptr] <= mem_rdata_i;
    end

endmodule

// File: tb/tb_lsu_wb_queue.sv
// Bench for lsu_wb_queue: directed scenarios with literal expectations, then random traffic
// checked every cycle against a queue-based reference model.
module tb_lsu_wb_queue;

    localparam int DW  = 32;
    localparam int RW  = 5;
    localparam int DEP = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cancel, hold, in_valid, in_is_load, in_wen, in_fence, mem_ok, wb_ready;
    logic [DW-1:0] in_result, mem_rdata;
    logic [RW-1:0] in_rd;
    logic [2:0]    in_func3;
    logic          in_ready, wb_valid, wb_wen, wb_fence, load_pending, empty;
    logic [DW-1:0] wb_data;
    logic [RW-1:0] wb_rd;

    int n_cmp = 0;
    int n_bad = 0;

    lsu_wb_queue #(.DATA_WIDTH(DW), .RD_WIDTH(RW), .DEPTH(DEP)) dut (
        .clk(clk), .rst_n(rst_n), .cancel_i(cancel), .hold_i(hold),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_result_i(in_result),
        .in_is_load_i(in_is_load), .in_wen_i(in_wen), .in_rd_i(in_rd),
        .in_func3_i(in_func3), .in_fence_i(in_fence), .mem_data_ok_i(mem_ok),
        .mem_rdata_i(mem_rdata), .wb_valid_o(wb_valid), .wb_ready_i(wb_ready),
        .wb_data_o(wb_data), .wb_rd_o(wb_rd), .wb_wen_o(wb_wen), .wb_fence_o(wb_fence),
        .load_pending_o(load_pending), .empty_o(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: program-ordered list of entries plus an owed-response counter.
    typedef struct {
        logic [DW-1:0] result;
        logic [DW-1:0] data;
        logic [RW-1:0] rd;
        logic [2:0]    f3;
        bit            is_load;
        bit            wen;
        bit            fence;
        bit            has;
    } ent_t;

    ent_t mq[$];
    int   m_drop = 0;

    function automatic logic [DW-1:0] mdl_mask(input logic [DW-1:0] raw, input logic [DW-1:0] addr,
                                               input logic [2:0] f3);
        longint unsigned r, v;
        int lane;
        r    = 64'(raw);
        lane = int'(addr % 4);
        case (f3)
            3'd0, 3'd4: begin
                v = (r >> (8 * lane)) & 64'hFF;
                if (f3 == 3'd0 && v >= 64'h80) v = v | ~64'hFF;
            end
            3'd1, 3'd5: begin
                v = (r >> (8 * ((lane / 2) * 2))) & 64'hFFFF;
                if (f3 == 3'd1 && v >= 64'h8000) v = v | ~64'hFFFF;
            end
            3'd2, 3'd6: v = r & 64'hFFFF_FFFF;
            default:    v = r;
        endcase
        return DW'(v);
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_drop = 0;
        end else begin
            int   pidx;
            bit   take, e_valid, e_ready, byp;
            logic [DW-1:0] e_data;
            ent_t e;
            pidx = -1;
            for (int i = 0; i < mq.size(); i++)
                if (pidx < 0 && mq[i].is_load && !mq[i].has) pidx = i;
            take    = mem_ok && m_drop == 0 && pidx >= 0;
            byp     = take && pidx == 0;
            e_valid = mq.size() > 0 && (!mq[0].is_load || mq[0].has || byp);
            e_ready = mq.size() < DEP && m_drop == 0 && !cancel;
            if (mq.size() == 0)   e_data = '0;
            else if (!mq[0].is_load) e_data = mq[0].result;
            else e_data = mdl_mask(byp ? mem_rdata : mq[0].data, mq[0].result, mq[0].f3);

            chk("in_ready", 64'(in_ready), 64'(e_ready));
            chk("wb_valid", 64'(wb_valid), 64'(e_valid));
            chk("wb_wen", 64'(wb_wen), 64'(e_valid && mq[0].wen));
            chk("wb_fence", 64'(wb_fence), 64'(e_valid && mq[0].fence));
            chk("load_pending", 64'(load_pending), 64'(pidx >= 0));
            chk("empty", 64'(empty), 64'(mq.size() == 0));
            chk("wb_rd", 64'(wb_rd), mq.size() == 0 ? 64'd0 : 64'(mq[0].rd));
            if (e_valid || mq.size() == 0) chk("wb_data", 64'(wb_data), 64'(e_data));

            if (take) begin
                e = mq[pidx];
                e.has  = 1'b1;
                e.data = mem_rdata;
                mq[pidx] = e;
            end else if (mem_ok && m_drop > 0) begin
                m_drop--;
            end
            if (e_valid && wb_ready && !hold) void'(mq.pop_front());
            if (cancel) begin
                foreach (mq[i]) if (mq[i].is_load && !mq[i].has) m_drop++;
                mq.delete();
            end
            if (in_valid && e_ready) begin
                e.result  = in_result;
                e.data    = '0;
                e.rd      = in_rd;
                e.f3      = in_func3;
                e.is_load = in_is_load;
                e.wen     = in_wen;
                e.fence   = in_fence;
                e.has     = !in_is_load;
                mq.push_back(e);
            end
        end
    end

    task automatic idle();
        cancel = 0; hold = 0; in_valid = 0; in_is_load = 0; in_wen = 0; in_fence = 0;
        mem_ok = 0; wb_ready = 1; in_result = '0; mem_rdata = '0; in_rd = '0; in_func3 = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic put(input logic [DW-1:0] res, input bit ld, input logic [RW-1:0] rd,
                       input logic [2:0] f3);
        in_valid = 1; in_result = res; in_is_load = ld; in_rd = rd; in_func3 = f3; in_wen = 1;
    endtask

    task automatic resp(input logic [DW-1:0] d);
        mem_ok = 1; mem_rdata = d;
    endtask

    initial begin
        idle();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        #2;
        chk("rst wb_valid", 64'(wb_valid), 0);
        chk("rst in_ready", 64'(in_ready), 1);
        chk("rst empty", 64'(empty), 1);
        chk("rst load_pending", 64'(load_pending), 0);
        chk("rst wb_data", 64'(wb_data), 0);
        chk("rst wb_rd", 64'(wb_rd), 0);

        // Non-load pass-through
        cyc(); put(32'h1234, 0, 5, 3'd0); #2 chk("t1 valid t", 64'(wb_valid), 0);
        cyc(); #2;
        chk("t1 valid t+1", 64'(wb_valid), 1);
        chk("t1 data", 64'(wb_data), 64'h1234);
        chk("t1 rd", 64'(wb_rd), 5);
        cyc(); #2 chk("t1 pulse", 64'(wb_valid), 0);

        // LB bypass
        cyc(); put(32'h103, 1, 7, 3'd0);
        cyc(); #2 chk("t2 wait valid", 64'(wb_valid), 0);
        cyc(); #2 chk("t2 pending", 64'(load_pending), 1);
        cyc(); resp(32'h80FF_FFFF); #2;
        chk("t2 bypass valid", 64'(wb_valid), 1);
        chk("t2 bypass data", 64'(wb_data), 64'hFFFF_FF80);
        cyc(); #2 chk("t2 empty", 64'(empty), 1);

        // Outstanding loads under commit stall
        cyc(); wb_ready = 0; put(32'h2, 1, 1, 3'd4);
        cyc(); wb_ready = 0; put(32'h2, 1, 2, 3'd5); resp(32'h00AB_0000);
        cyc(); wb_ready = 0; resp(32'hBEEF_0000);
        cyc(); #2;
        chk("t3 c1 valid", 64'(wb_valid), 1);
        chk("t3 c1 data", 64'(wb_data), 64'hAB);
        cyc(); #2;
        chk("t3 c2 valid", 64'(wb_valid), 1);
        chk("t3 c2 data", 64'(wb_data), 64'hBEEF);
        cyc(); #2 chk("t3 empty", 64'(empty), 1);

        // Full queue
        for (int i = 0; i < DEP; i++) begin
            cyc(); put(DW'(4 * i), 1, RW'(8 + i), 3'd2);
        end
        cyc(); put(32'h55, 0, 1, 3'd0); #2 chk("t4 full ready", 64'(in_ready), 0);
        cyc(); resp(32'h1111_1111); #2;
        chk("t4 commit valid", 64'(wb_valid), 1);
        chk("t4 still full", 64'(in_ready), 0);
        cyc(); #2 chk("t4 ready back", 64'(in_ready), 1);
        for (int i = 0; i < DEP - 1; i++) begin
            cyc(); resp(DW'(i + 2));
        end
        cyc(); #2 chk("t4 drained", 64'(empty), 1);

        // Cancel with three loads in flight
        for (int i = 0; i < 3; i++) begin
            cyc(); put(DW'(i), 1, RW'(i + 1), 3'd2);
        end
        cyc(); cancel = 1; #2 chk("t5 cancel ready", 64'(in_ready), 0);
        cyc(); #2;
        chk("t5 empty", 64'(empty), 1);
        chk("t5 ready", 64'(in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            cyc(); resp(32'hDEAD_0000); #2;
            chk("t5 drop ready", 64'(in_ready), 0);
            chk("t5 drop valid", 64'(wb_valid), 0);
        end
        cyc(); #2 chk("t5 ready after drops", 64'(in_ready), 1);

        // Cancel together with bypass commit and response
        cyc(); put(32'h0, 1, 3, 3'd2);
        cyc(); put(32'h4, 1, 4, 3'd2);
        cyc(); resp(32'hCAFE_F00D); cancel = 1; #2;
        chk("t6 head valid", 64'(wb_valid), 1);
        chk("t6 head data", 64'(wb_data), 64'hCAFE_F00D);
        chk("t6 head rd", 64'(wb_rd), 3);
        cyc(); #2;
        chk("t6 empty", 64'(empty), 1);
        chk("t6 drop ready", 64'(in_ready), 0);
        cyc(); resp(32'h1); #2 chk("t6 dropped", 64'(wb_valid), 0);
        cyc(); #2 chk("t6 ready back", 64'(in_ready), 1);

        // Random traffic with a mid-run reset
        for (int c = 0; c < 3000; c++) begin
            cyc();
            if (c == 1500 || c == 1501) begin
                rst_n = 0;
            end else begin
                rst_n      = 1;
                in_valid   = ($urandom_range(99) < 60);
                in_is_load = ($urandom_range(1) == 1);
                in_result  = $urandom;
                in_rd      = RW'($urandom);
                in_func3   = 3'($urandom);
                in_wen     = ($urandom_range(3) != 0);
                in_fence   = ($urandom_range(7) == 0);
                mem_ok     = ($urandom_range(99) < 40);
                mem_rdata  = $urandom;
                wb_ready   = ($urandom_range(99) < 70);
                hold       = ($urandom_range(9) == 0);
                cancel     = ($urandom_range(99) < 3);
            end
        end
        cyc();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu_wb_queue.md
# lsu_wb_queue

Parametrised writeback queue between the execute/memory stage and the register file. It generalises the single-entry writeback stage to DEPTH in-order entries with multiple outstanding loads. It handles in-order memory responses with load byte/halfword/word masking at any DATA_WIDTH, and absorbs responses for cancelled loads with a drop counter instead of a single-entry leap state. Entries retire in program order to the register file under a valid/ready handshake.

## Interface
- DATA_WIDTH, 32, datapath width; 32 or 64.
- RD_WIDTH, 5, destination register index width.
- DEPTH, 4, queue entries and maximum outstanding loads; power of 2, at least 2.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cancel  in  1  flush every entry that does not commit this cycle.
- hold  in  1  stall: blocks commit only.
- in_valid  in  1  upstream entry offered.
- in_ready  out  1  entry accepted when in_valid && in_ready.
- in_result  in  DATA_WIDTH  ALU result, or load address for loads.
- in_is_load  in  1  entry waits for one memory response.
- in_wen  in  1  entry writes rd.
- in_rd  in  RD_WIDTH  destination register.
- in_func3  in  3  load mask type.
- in_fence  in  1  fence marker, passed through.
- mem_data_ok  in  1  one in-order load response this cycle.
- mem_rdata  in  DATA_WIDTH  raw response word.
- wb_valid  out  1  head entry complete.
- wb_ready  in  1  regfile accepts.
- wb_data  out  DATA_WIDTH  masked load data or result.
- wb_rd  out  RD_WIDTH  head destination register.
- wb_wen  out  1  in_wen of head, gated by wb_valid.
- wb_fence  out  1  in_fence of head, gated by wb_valid.
- load_pending  out  1  some queued load has no data yet.
- empty  out  1  count == 0.

## Operation
- Storage is a circular buffer with head and tail pointers and a count of width log2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Each entry holds: result, is_load, wen, rd, func3, fence, data_valid, raw data.
- A separate response pointer marks the oldest load with data_valid=0.
- **Enqueue:** `in_ready = (count < DEPTH) && (drop_cnt == 0) && !cancel`. A load is queued with data_valid=0; a non-load is queued with data_valid=1.
- **Response handling:**
  - If drop_cnt != 0, mem_data_ok decrements drop_cnt and the data is discarded.
  - Otherwise the data is written to the entry at the response pointer, that entry's data_valid is set, and the response pointer advances to the next load.
  - mem_data_ok with no pending load and drop_cnt == 0 is ignored.
- **Head complete:** the head has data_valid=1, or it is the response-pointer entry and mem_data_ok=1 with drop_cnt=0 (bypass path).
- `wb_valid = !empty && head complete`.
- **Commit:** `wb_valid && wb_ready && !hold`; the head is popped.
- **wb_data:** result for non-loads. For loads, mem_rdata on bypass, otherwise the stored data, masked with lane = result[log2(DATA_WIDTH/8)-1:0]:
  - 000 LB: byte, sign-extended.
  - 001 LH: halfword at lane[..:1], sign-extended.
  - 010 LW: word, sign-extended to DATA_WIDTH.
  - 100 LBU, 101 LHU, 110 LWU: zero-extended.
  - 011 LD: full word when DATA_WIDTH=64.
  - Any other func3: raw word.
- **Cancel:**
  - A commit in the same cycle still retires.
  - All other entries are invalidated and head = tail.
  - drop_cnt is set to the number of invalidated loads with data_valid=0, minus 1 if mem_data_ok is consumed by one of them this cycle.
- Simultaneous enqueue and commit leaves count unchanged. A full queue accepts an entry only if count < DEPTH before the edge; there is no pass-through when full.

## Timing
- Reset values: wb_valid=0, wb_wen=0, wb_fence=0, wb_data=0, wb_rd=0, in_ready=1, empty=1, load_pending=0, drop_cnt=0, all pointers 0.
- wb_data and wb_rd are 0 when empty.
- Non-load accepted at cycle t into an empty queue: wb_valid=1 at t+1.
- Load accepted at t: the earliest response is t+1. Its mem_data_ok cycle shows wb_valid=1 combinationally if the load is at the head.
- Stored responses are presented from the cycle after mem_data_ok.
- While drop_cnt > 0, in_ready=0. in_ready returns in the cycle after the last dropped response.
- Throughput is one commit per cycle.
- Reset mid-operation clears everything, including drop_cnt.

## Test plan
- **Non-load pass-through:** enqueue result 0x1234, rd=5, wen=1; wb_ready=1. Required: wb_valid at t+1, wb_data=0x1234, one-cycle pulse.
- **LB bypass:** enqueue load addr 0x103 func3=000; mem_rdata=0x80FFFFFF at t+3. Required: wb_valid and wb_data=0xFFFFFF80 in cycle t+3.
- **Outstanding loads with commit stall:** enqueue loads LBU@0x2 and LHU@0x2 with wb_ready=0; responses 0x00AB0000 then 0xBEEF0000; then wb_ready=1. Required: commits 0x000000AB then 0x0000BEEF on consecutive cycles.
- **Full queue:** DEPTH=4, four loads with no responses. Required: in_ready=0. One response plus commit raises in_ready the next cycle.
- **Cancel with in-flight loads:** three loads queued, none answered; cancel. Required: empty=1, in_ready=0, the next three mem_data_ok are discarded, in_ready=1 after the third.
- **Cancel same cycle as commit and response:** head bypass commit plus one younger pending load. Required: the head retires, drop_cnt=1, and the following response is dropped.
